// File: rtl/cq_pkg.sv
// Shared sizing defaults and mode encodings for the cyclic replay queue.
package cq_pkg;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;
endpackage

// File: rtl/cq_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module cq_mem
    import cq_pkg::*;
#(
    parameter int MEM_DATA_W = DATA_W,
    parameter int MEM_DEPTH  = DEPTH,
    parameter int MEM_ADDR_W = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MEM_ADDR_W-1:0] waddr,
    input  logic [MEM_DATA_W-1:0] wdata,
    input  logic [MEM_ADDR_W-1:0] raddr,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [MEM_DEPTH];

    // Contents are intentionally never reset so a loaded set survives rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cyclic_queue.sv
// Circular buffer whose reads are non-destructive and wrap to the oldest stored
// word, so a loaded set of words can be replayed indefinitely.
module cyclic_queue
    import cq_pkg::*;
#(
    parameter int Q_DATA_W = DATA_W,
    parameter int Q_DEPTH  = DEPTH,
    parameter int Q_ADDR_W = $clog2(Q_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                En,
    input  logic                mode,
    input  logic [Q_DATA_W-1:0] Data_In,
    output logic [Q_DATA_W-1:0] Data_Out
);

    localparam logic [Q_ADDR_W:0]   CNT_FULL = (Q_ADDR_W+1)'(Q_DEPTH);
    localparam logic [Q_ADDR_W-1:0] PTR_ONE  = Q_ADDR_W'(1);

    logic [Q_ADDR_W-1:0] wr_ptr;
    logic [Q_ADDR_W-1:0] rd_ptr;
    logic [Q_ADDR_W:0]   count;
    logic [Q_DATA_W-1:0] rdata;

    logic                do_write;
    logic                do_read;
    logic                full;
    logic                empty;
    logic [Q_ADDR_W-1:0] wr_step;
    logic [Q_ADDR_W-1:0] rd_step;
    logic [Q_ADDR_W-1:0] rd_after_read;

    assign do_write = En && (mode == MODE_WRITE);
    assign do_read  = En && (mode == MODE_READ);
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign wr_step  = wr_ptr + PTR_ONE;
    assign rd_step  = rd_ptr + PTR_ONE;

    // Until full the valid words sit at 0..wr_ptr-1, so stepping onto wr_ptr means
    // we passed the newest word and must restart at 0. Once full, the oldest word
    // is at wr_ptr itself, which plain modulo stepping already reaches.
    assign rd_after_read = (!full && (rd_step == wr_ptr)) ? '0 : rd_step;

    cq_mem #(
        .MEM_DATA_W (Q_DATA_W),
        .MEM_DEPTH  (Q_DEPTH),
        .MEM_ADDR_W (Q_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_write && !rst),
        .waddr (wr_ptr),
        .wdata (Data_In),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Data_Out <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_step;
            if (!full) begin
                count <= count + (Q_ADDR_W+1)'(1);
            end else if (rd_ptr == wr_ptr) begin
                // The oldest word is being overwritten; keep rd_ptr on the new oldest.
                rd_ptr <= rd_step;
            end
        end else if (do_read) begin
            if (empty) begin
                Data_Out <= '0;
            end else begin
                Data_Out <= rdata;
                rd_ptr   <= rd_after_read;
            end
        end
    end

endmodule

// File: tb/tb_cyclic_queue.sv
// Scoreboard bench for cyclic_queue: the driver queues the expected Data_Out for
// every clock edge and a negedge monitor pops and compares.
module tb_cyclic_queue;
    import cq_pkg::*;

    logic        clk;
    logic        rst;
    logic        En;
    logic        mode;
    logic [31:0] Data_In;
    logic [31:0] Data_Out;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_cmp;
    int          n_mis;

    logic [31:0] d_words [12];
    logic [31:0] e_words [12];
    logic [31:0] w_words [67];
    logic [31:0] de_seq  [24];
    logic [31:0] last_exp;

    cyclic_queue dut (
        .clk      (clk),
        .rst      (rst),
        .En       (En),
        .mode     (mode),
        .Data_In  (Data_In),
        .Data_Out (Data_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [31:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if (Data_Out !== e) begin
                n_mis++;
                $display("FAIL %s: Data_Out got %h expected %h at %0t", t, Data_Out, e, $time);
            end
        end
    end

    task automatic cyc(input logic r, input logic en_i, input logic mode_i,
                       input logic [31:0] din, input logic [31:0] exp, input string tag);
        rst     = r;
        En      = en_i;
        mode    = mode_i;
        Data_In = din;
        @(posedge clk);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        last_exp = exp;
        #1;
    endtask

    task automatic wr(input logic [31:0] din, input string tag);
        cyc(1'b0, 1'b1, MODE_WRITE, din, last_exp, tag);
    endtask

    task automatic rd(input logic [31:0] exp, input string tag);
        cyc(1'b0, 1'b1, MODE_READ, 32'h0, exp, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, MODE_READ, 32'hDEAD_BEEF, last_exp, tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        last_exp = '0;
        rst      = 1'b0;
        En       = 1'b0;
        mode     = MODE_READ;
        Data_In  = '0;
        for (int i = 0; i < 12; i++) begin
            d_words[i] = 32'hD000_0000 + 32'(i);
            e_words[i] = 32'hE000_0100 + 32'(i * 3);
            de_seq[i]      = d_words[i];
            de_seq[i + 12] = e_words[i];
        end
        for (int i = 0; i < 67; i++) begin
            w_words[i] = 32'hA500_0000 + 32'(i * 17);
        end

        // Reset, then a read on the empty queue.
        cyc(1'b1, 1'b0, MODE_READ, 32'h0, 32'h0, "reset");
        rd(32'h0, "read_empty_after_reset");

        // Write D0..D11 as single-cycle pulses with two idle cycles between.
        for (int i = 0; i < 12; i++) begin
            wr(d_words[i], "write_d_hold");
            idle("write_gap_hold");
            idle("write_gap_hold");
        end
        for (int i = 0; i < 12; i++) begin
            rd(d_words[i], "replay_d");
        end
        rd(d_words[0], "replay_wrap_d0");

        // Freeze mid-stream, then resume with the following word.
        for (int i = 0; i < 3; i++) idle("idle_hold");
        rd(d_words[1], "resume_d1");
        rd(d_words[2], "resume_d2");

        // Append E0..E11; replay continues from rd_ptr=3 across the 24-word cycle.
        for (int i = 0; i < 12; i++) wr(e_words[i], "append_e_hold");
        for (int k = 0; k < 26; k++) begin
            rd(de_seq[(3 + k) % 24], "replay_de");
        end

        // Reset during continuous reads, then read on empty.
        rd(de_seq[(3 + 26) % 24], "pre_reset_read");
        cyc(1'b1, 1'b1, MODE_READ, 32'h0, 32'h0, "reset_mid_read");
        rd(32'h0, "read_empty_after_reset2");
        rd(32'h0, "read_empty_after_reset3");

        // Overfill by three; replay starts at the oldest surviving word W3.
        for (int i = 0; i < 67; i++) wr(w_words[i], "full_write_hold");
        for (int k = 0; k < 64; k++) begin
            rd(w_words[3 + k], "full_replay");
        end
        rd(w_words[3], "full_replay_wrap_w3");
        rd(w_words[4], "full_replay_wrap_w4");

        // Reset overrides a write request.
        cyc(1'b1, 1'b1, MODE_WRITE, 32'h1234_5678, 32'h0, "reset_over_write");
        rd(32'h0, "read_empty_after_reset4");
        idle("final_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: pending expectations %0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
